btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
Input-conditioning stage between the raw board push-buttons (BtnC/U/D/L/R) and the game logic/block controller.
- Synchronises each asynchronous button to clk.
- Debounces each button with its own counter.
- Presents a clean level, plus single-cycle press and release pulses.
- Movement logic consumes these pulses instead of the raw pins, so one physical press yields exactly one move event.

Parameters:
N_BTN, 5, number of independent button channels (bit order {C,U,D,L,R} = [4:0] at top level)
DEB_CYCLES, 1000000, consecutive stable clk cycles required to accept a new level (10 ms at 100 MHz); legal range 2..2^CNT_W-1
CNT_W, 20, width of each debounce counter
REP_DELAY, 50000000, cycles a button must be held before auto-repeat starts (only used with BTN_REPEAT_EN)
REP_PERIOD, 10000000, cycles between auto-repeat pulses (only used with BTN_REPEAT_EN)

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
btn_raw  input  N_BTN  raw asynchronous button pins, 1 = pressed
btn_level  output  N_BTN  debounced button level
btn_press  output  N_BTN  1-cycle pulse on each accepted 0->1 transition (and on auto-repeat ticks when enabled)
btn_release  output  N_BTN  1-cycle pulse on each accepted 1->0 transition
any_press  output  1  OR of btn_press, same cycle

Behaviour:
- Reset (rst=0, asynchronous): sync flops, counters, btn_level, btn_press, btn_release and any_press all go to 0 immediately. Channel FSMs go to IDLE.
- Release of reset is synchronous to clk. The first sample is taken on the first rising edge with rst=1.
- Synchroniser: two flops per channel. s = second flop output.
- Per-channel FSM, states IDLE (level 0), PRESS_WAIT, HELD (level 1), REL_WAIT. Counter cnt is CNT_W bits.
  - IDLE: if s=1, go to PRESS_WAIT with cnt=1. Otherwise cnt=0.
  - PRESS_WAIT:
    - s=0: return to IDLE, cnt=0 (glitch rejected, no pulse).
    - s=1 and cnt=DEB_CYCLES-1: go to HELD, set btn_level=1, cnt=0, assert btn_press for exactly one cycle (registered, same edge level rises).
    - Otherwise cnt+1.
  - HELD: if s=0, go to REL_WAIT with cnt=1.
  - REL_WAIT: symmetric to PRESS_WAIT.
    - s=1: back to HELD, no pulse.
    - s=0 and cnt=DEB_CYCLES-1: go to IDLE, btn_level=0, btn_release one cycle.
- Latency: a clean step on btn_raw reaches btn_level/btn_press exactly DEB_CYCLES+2 rising edges after the first edge that samples the new value.
- Counter never wraps. It is bounded by DEB_CYCLES-1 and cleared on every state exit.
- Channels are fully independent. Simultaneous presses produce simultaneous pulses on their respective bits. any_press is the OR of them and is still a single cycle.
- btn_press and btn_release of one channel are never asserted in the same cycle.
- Reset asserted mid-debounce or while HELD clears everything; no release pulse is generated.
- A button held through reset release is accepted as a new press after DEB_CYCLES+2 cycles.

Optional Feature:
Macro BTN_REPEAT_EN.
- Defined: in HELD, a per-channel repeat counter runs.
  - First extra btn_press pulse after REP_DELAY cycles in HELD.
  - Then one pulse every REP_PERIOD cycles while still HELD.
  - Counter clears on entry to HELD and on leaving HELD; REL_WAIT pauses repeats.
  - btn_level is unaffected.
- Undefined: no repeat counter logic exists, REP_* parameters are ignored, and btn_press fires only once per press.

Test Plan:
- Reset: hold rst=0 with btn_raw=5'h1F for 20 cycles -> all outputs 0. Release rst, use DEB_CYCLES=4 -> btn_level=5'h1F and btn_press=5'h1F for one cycle, 6 edges after release.
- Clean press/release, DEB_CYCLES=4, bit1 steps 0->1 -> btn_press[1] high one cycle at edge 6 and btn_level[1]=1. Step 1->0 later -> btn_release[1] one cycle at edge 6 and btn_level[1]=0.
- Bounce rejection: bit3 toggles 1,0,1,0 every 2 cycles, then stays 1 -> exactly one btn_press[3], 6 edges after the final rising step, no btn_release.
- Simultaneous events: bits 0 and 4 rise on the same edge -> btn_press=5'b10001 for one cycle and any_press=1 for one cycle. Bit 2 bouncing at the same time has no effect on them.
- Mid-operation reset: assert rst=0 while bit2 is HELD -> btn_level[2] drops immediately and no btn_release[2] is seen.
- BTN_REPEAT_EN, REP_DELAY=10, REP_PERIOD=3, hold bit1 for 30 cycles after HELD -> btn_press[1] pulses at HELD+0, +10, +13, +16, ..., +28. None follow release.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-channel 2-flop synchroniser, debounce FSM,
// clean level plus single-cycle press/release pulses.
// Optional auto-repeat of press pulses while held: define BTN_REPEAT_EN.

// One button channel: synchroniser, debounce FSM, registered outputs.
module btn_channel #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
`ifdef BTN_REPEAT_EN
  , parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 10000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1, s;

`ifdef BTN_REPEAT_EN
  localparam logic [31:0] REP_LAST_D = 32'(REP_DELAY - 1);
  localparam logic [31:0] REP_LAST_P = 32'(REP_PERIOD - 1);
  // rphase=0: waiting out the initial delay; rphase=1: periodic ticks
  logic [31:0] rcnt;
  logic        rphase;
`endif

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  // Debounce FSM; level/press/rel are registered and change on the accepting edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
`ifdef BTN_REPEAT_EN
      rcnt   <= '0;
      rphase <= 1'b0;
`endif
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state  <= HELD;
            level  <= 1'b1;
            press  <= 1'b1;
            cnt    <= '0;
`ifdef BTN_REPEAT_EN
            rcnt   <= '0;
            rphase <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            state  <= REL_WAIT;
            cnt    <= CNT_ONE;
`ifdef BTN_REPEAT_EN
            rcnt   <= '0;
            rphase <= 1'b0;
          end else if (rcnt == (rphase ? REP_LAST_P : REP_LAST_D)) begin
            press  <= 1'b1;
            rcnt   <= '0;
            rphase <= 1'b1;
          end else begin
            rcnt   <= rcnt + 32'd1;
`endif
          end
        end
        REL_WAIT: begin
          if (s) begin
            // bounce back to held: no pulse, repeat timing restarts
            state  <= HELD;
            cnt    <= '0;
`ifdef BTN_REPEAT_EN
            rcnt   <= '0;
            rphase <= 1'b0;
`endif
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            level <= 1'b0;
            rel   <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// Top: independent channels, bit order {C,U,D,L,R} = [4:0] for N_BTN=5.
module btn_conditioner #(
  parameter int N_BTN      = 5,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);
  // Elaboration-time legality checks; the counter must hold DEB_CYCLES-1
  if (DEB_CYCLES < 2 || DEB_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_deb
    $error("btn_conditioner: DEB_CYCLES out of range for CNT_W");
  end
  if (REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_rep
    $error("btn_conditioner: REP_DELAY and REP_PERIOD must be >= 1");
  end

  btn_channel #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
`ifdef BTN_REPEAT_EN
    , .REP_DELAY  (REP_DELAY),
    .REP_PERIOD (REP_PERIOD)
`endif
  ) u_ch [N_BTN-1:0] (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_raw),
    .level (btn_level),
    .press (btn_press),
    .rel   (btn_release)
  );

  // Presses are already single-cycle registered pulses, so the OR is too
  assign any_press = |btn_press;
endmodule
